// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: FSM states, PC-select codes and default widths shared by fetch, branch unit and decode.
package fetch_sequencer_pkg;
    localparam int AW_DEF = 8;
    localparam int IW_DEF = 16;
    typedef enum logic [1:0] {S_BOOT = 2'd0, S_FETCH = 2'd1, S_REDIR = 2'd2} state_e;
    typedef enum logic [1:0] {PC_HOLD = 2'd0, PC_INC = 2'd1, PC_TGT = 2'd2} pc_sel_e;
endpackage

// File: rtl/fetch_sequencer_pc_next_mux.sv
// pc_next_mux: next-PC selection between hold, sequential step and branch target.
module pc_next_mux
    import fetch_sequencer_pkg::*;
#(
    parameter int AW  = AW_DEF,
    parameter int INC = 1
) (
    input  logic [AW-1:0] pc,
    input  logic [AW-1:0] target,
    input  pc_sel_e       sel,
    output logic [AW-1:0] pc_next
);
    always_comb pc_next = sel == PC_TGT ? target : sel == PC_INC ? pc + AW'(INC) : pc;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, issues instruction-memory reads and redirects fetch on taken branches.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int            AW       = AW_DEF,
    parameter int            IW       = IW_DEF,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int            INC      = 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,
    input  logic          stall,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata,
    output logic [IW-1:0] instr_out,
    output logic          instr_valid,
    output logic [AW-1:0] pc_out,
    output logic          flush
);
    state_e        state_q, state_d;
    pc_sel_e       pc_sel;
    logic [AW-1:0] pc_q, pc_d, pc_out_q, pc_out_d;
    logic [IW-1:0] instr_q, instr_d;
    logic          valid_q, valid_d, flush_q, flush_d;

    assign imem_req    = state_q == S_FETCH && !stall;
    assign imem_addr   = pc_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign pc_out      = pc_out_q;
    assign flush       = flush_q;

    pc_next_mux #(.AW(AW), .INC(INC)) u_pc_next_mux (
        .pc      (pc_q),
        .target  (branch_target),
        .sel     (pc_sel),
        .pc_next (pc_d)
    );

    // A branch outranks an ack in the same cycle, so that word is dropped.
    always_comb begin
        state_d  = state_q;
        pc_sel   = PC_HOLD;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = 1'b0;
        flush_d  = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                if (branch_taken) begin
                    pc_sel  = PC_TGT;
                    flush_d = 1'b1;
                    state_d = S_REDIR;
                end else if (imem_ack && imem_req) begin
                    pc_sel   = PC_INC;
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                end
            end
            S_REDIR: begin
                if (branch_taken) begin
                    pc_sel  = PC_TGT;
                    flush_d = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_BOOT;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            pc_out_q <= RESET_PC;
            valid_q  <= 1'b0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            flush_q  <= flush_d;
        end
    end
endmodule
